div: RTL and testbench



---
 rtl/div_pkg.sv | 38 +++
 rtl/div_if.sv | 24 ++
 rtl/div.sv | 117 +++++++++++
 tb/tb_div.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: bus widths, FSM
// encodings, handshake constants and word-level sign helpers.
package div_pkg;

   localparam int unsigned RegBus       = 32;
   localparam int unsigned DoubleRegBus = 64;
   localparam int unsigned CntW         = 6;

   localparam logic [RegBus-1:0] ZeroWord = '0;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // {HI, LO} layout of the result bus
   typedef struct packed {
      logic [RegBus-1:0] rem;
      logic [RegBus-1:0] quot;
   } div_result_t;

   function automatic logic [RegBus-1:0] neg_word(input logic [RegBus-1:0] x);
      return ~x + RegBus'(1);
   endfunction

   function automatic logic [RegBus-1:0] abs_word(input logic [RegBus-1:0] x,
                                                  input logic              is_signed);
      return (is_signed && x[RegBus-1]) ? neg_word(x) : x;
   endfunction

endpackage

// File: rtl/div_if.sv
// Execute-stage <-> divider handshake: operands and start/annul in,
// {HI, LO} result and ready out.
interface div_if;
   import div_pkg::*;

   logic                    signed_div_i;
   logic [RegBus-1:0]       opdata1_i;
   logic [RegBus-1:0]       opdata2_i;
   logic                    start_i;
   logic                    annul_i;
   logic [DoubleRegBus-1:0] result_o;
   logic                    ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );

endinterface

// File: rtl/div.sv
// Restoring shift-subtract divider, one quotient bit per cycle, with
// magnitude division followed by a sign fix for DIV.
module div
   import div_pkg::*;
(
   input logic  clk,
   input logic  rst,
   div_if.slave bus
);

   div_state_e              r_state, w_state_n;
   logic [CntW-1:0]         r_cnt, w_cnt_n;
   logic [DoubleRegBus:0]   r_w, w_w_n;
   logic [RegBus-1:0]       r_divisor, w_divisor_n;
   logic                    r_q_neg, w_q_neg_n;
   logic                    r_r_neg, w_r_neg_n;
   logic [DoubleRegBus-1:0] r_result, w_result_n;
   logic                    r_ready, w_ready_n;

   logic [RegBus:0]         w_sub;
   logic [DoubleRegBus:0]   w_step;
   logic [RegBus-1:0]       w_quot, w_rem;
   div_result_t             w_fixed;

   // Bit 64 is always clear before a step, so this equals the zero-extended form.
   assign w_sub  = r_w[DoubleRegBus:RegBus] - {1'b0, r_divisor};
   assign w_step = w_sub[RegBus] ? {r_w[DoubleRegBus-1:0], 1'b0}
                                 : {w_sub[RegBus-1:0], r_w[RegBus-1:0], 1'b1};

   assign w_quot       = w_step[RegBus-1:0];
   assign w_rem        = w_step[DoubleRegBus:RegBus+1];
   assign w_fixed.quot = r_q_neg ? neg_word(w_quot) : w_quot;
   assign w_fixed.rem  = r_r_neg ? neg_word(w_rem) : w_rem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= DivFree;
         r_cnt     <= '0;
         r_w       <= '0;
         r_divisor <= '0;
         r_q_neg   <= 1'b0;
         r_r_neg   <= 1'b0;
         r_result  <= '0;
         r_ready   <= DivResultNotReady;
      end else begin
         r_state   <= w_state_n;
         r_cnt     <= w_cnt_n;
         r_w       <= w_w_n;
         r_divisor <= w_divisor_n;
         r_q_neg   <= w_q_neg_n;
         r_r_neg   <= w_r_neg_n;
         r_result  <= w_result_n;
         r_ready   <= w_ready_n;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_cnt_n     = r_cnt;
      w_w_n       = r_w;
      w_divisor_n = r_divisor;
      w_q_neg_n   = r_q_neg;
      w_r_neg_n   = r_r_neg;
      w_result_n  = r_result;
      w_ready_n   = r_ready;

      unique case (r_state)
         DivFree: begin
            if (bus.start_i == DivStart && !bus.annul_i) begin
               w_q_neg_n = bus.signed_div_i & (bus.opdata1_i[RegBus-1] ^ bus.opdata2_i[RegBus-1]);
               w_r_neg_n = bus.signed_div_i & bus.opdata1_i[RegBus-1];
               if (bus.opdata2_i == ZeroWord) begin
                  w_state_n = DivByZero;
               end else begin
                  w_state_n   = DivOn;
                  w_divisor_n = abs_word(bus.opdata2_i, bus.signed_div_i);
                  w_cnt_n     = '0;
                  w_w_n       = {ZeroWord, abs_word(bus.opdata1_i, bus.signed_div_i), 1'b0};
               end
            end
         end
         DivByZero: begin
            w_state_n  = DivEnd;
            w_w_n      = '0;
            w_result_n = {ZeroWord, ZeroWord};
            w_ready_n  = DivResultReady;
         end
         DivOn: begin
            if (bus.annul_i || bus.start_i == DivStop) begin
               w_state_n  = DivFree;
               w_result_n = {ZeroWord, ZeroWord};
               w_ready_n  = DivResultNotReady;
            end else begin
               w_w_n   = w_step;
               w_cnt_n = r_cnt + CntW'(1);
               if (r_cnt == CntW'(RegBus - 1)) begin
                  w_state_n  = DivEnd;
                  w_result_n = w_fixed;
                  w_ready_n  = DivResultReady;
               end
            end
         end
         DivEnd: begin
            if (bus.start_i == DivStop) begin
               w_state_n  = DivFree;
               w_result_n = {ZeroWord, ZeroWord};
               w_ready_n  = DivResultNotReady;
            end
         end
         default: w_state_n = DivFree;
      endcase
   end

   assign bus.result_o = r_result;
   assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the divider: latency, signed/unsigned
// results, divide-by-zero, annul, reset and result hold behaviour.
module tb_div;
   import div_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   div_if bus ();

   div dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   // Called in the negedge of the start cycle; returns cycles until ready_o.
   task automatic wait_ready(output int lat);
      lat = 0;
      while (bus.ready_o !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [63:0] exp_res, input int hold);
      int   lat;
      logic stable;
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.annul_i      = 1'b0;
      bus.start_i      = 1'b1;
      wait_ready(lat);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " result"}, bus.result_o, exp_res);
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         bus.opdata1_i    = $urandom;
         bus.opdata2_i    = $urandom;
         bus.signed_div_i = ~sgn;
         @(negedge clk);
         if (bus.ready_o !== 1'b1 || bus.result_o !== exp_res) stable = 1'b0;
      end
      if (hold > 0) check({tag, " held result stable"}, 64'(stable), 64'd1);
      bus.start_i = 1'b0;
      @(negedge clk);
      check({tag, " ready after drop"}, 64'(bus.ready_o), 64'd0);
      check({tag, " result after drop"}, bus.result_o, 64'd0);
   endtask

   initial begin
      int   lat;
      logic rose;
      checks = 0;
      errors = 0;
      clk    = 1'b0;
      rst    = 1'b1;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;

      @(negedge clk);
      check("reset ready", 64'(bus.ready_o), 64'd0);
      check("reset result", bus.result_o, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle ready", 64'(bus.ready_o), 64'd0);

      run_div("u 100/7", 1'b0, 32'd100, 32'd7, 33, {32'h00000002, 32'h0000000E}, 0);
      run_div("s -7/2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 33, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
      run_div("s 7/-2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 33, {32'h00000001, 32'hFFFFFFFD}, 0);
      run_div("u 0xFFFFFFF9/2", 1'b0, 32'hFFFFFFF9, 32'h00000002, 33, {32'h00000001, 32'h7FFFFFFC}, 0);
      run_div("s div0", 1'b1, 32'h12345678, 32'h0, 2, 64'd0, 0);
      run_div("u div0", 1'b0, 32'h12345678, 32'h0, 2, 64'd0, 0);
      run_div("s min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, {32'h00000000, 32'h80000000}, 0);
      run_div("u max/1", 1'b0, 32'hFFFFFFFF, 32'h00000001, 33, {32'h00000000, 32'hFFFFFFFF}, 0);

      // Annul mid-division: block must go idle and never report a result.
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd1000;
      bus.opdata2_i    = 32'd3;
      bus.start_i      = 1'b1;
      repeat (10) @(negedge clk);
      bus.annul_i = 1'b1;
      @(negedge clk);
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      rose = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.ready_o !== 1'b0) rose = 1'b1;
      end
      check("annul ready never rose", 64'(rose), 64'd0);
      check("annul result", bus.result_o, 64'd0);
      run_div("u 9/4 after annul", 1'b0, 32'd9, 32'd4, 33, {32'h00000001, 32'h00000002}, 0);

      // Reset mid-division.
      bus.opdata1_i = 32'd1000;
      bus.opdata2_i = 32'd3;
      bus.start_i   = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid reset ready", 64'(bus.ready_o), 64'd0);
      check("mid reset result", bus.result_o, 64'd0);
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_div("u 9/4 after reset", 1'b0, 32'd9, 32'd4, 33, {32'h00000001, 32'h00000002}, 0);

      // Reset while a result is presented clears outputs without a clock edge.
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd100;
      bus.opdata2_i    = 32'd7;
      bus.start_i      = 1'b1;
      wait_ready(lat);
      check("pre-async latency", 64'(lat), 64'd33);
      rst = 1'b1;
      #1;
      check("async reset ready", 64'(bus.ready_o), 64'd0);
      check("async reset result", bus.result_o, 64'd0);
      @(negedge clk);
      bus.start_i = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      run_div("u 100/7 hold", 1'b0, 32'd100, 32'd7, 33, {32'h00000002, 32'h0000000E}, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
